servo_slew_limiter: RTL and testbench

- Sits between data_controller and pwm_driver on each servo channel.
- Takes the requested 13-bit pulse width (µs) and clamps it to the legal servo range.
- Drives pwm_driver's data input with a rate-limited value, so keyboard or replay jumps never slam the servo.
- Reports busy/settled status for the VGA status overlay and for replay sequencing.

---
 rtl/servo_pkg.sv | 21 ++
 rtl/servo_slew_limiter_if.sv | 23 ++
 rtl/step_tick_gen.sv | 32 +++
 rtl/servo_slew_limiter.sv | 117 +++++++++++
 tb/tb_servo_slew_limiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// Shared types and defaults for the servo slew limiter.
package servo_pkg;

  localparam int DATA_W       = 13;
  localparam int MIN_PW_DEF   = 500;
  localparam int MAX_PW_DEF   = 2500;
  localparam int RESET_PW_DEF = 1500;

  typedef logic [DATA_W-1:0] pw_t;

  // state   | meaning
  // IDLE    | o_data parked (== target_q, or waiting for enable/hold release)
  // RAMP    | stepping o_data toward target_q once per step period
  // HOLD    | ramp frozen mid-flight, counter and o_data held
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2
  } slew_state_t;

endpackage

// File: rtl/servo_slew_limiter_if.sv
// Channel bus between data_controller/pwm_driver side and the slew limiter.
interface servo_slew_limiter_if;
  import servo_pkg::*;

  pw_t  i_target;
  logic i_enable;
  logic i_hold;
  pw_t  o_data;
  logic o_busy;
  logic o_settled;
  logic o_update;

  modport master (
    output i_target, i_enable, i_hold,
    input  o_data, o_busy, o_settled, o_update
  );

  modport slave (
    input  i_target, i_enable, i_hold,
    output o_data, o_busy, o_settled, o_update
  );

endinterface

// File: rtl/step_tick_gen.sv
// Ramp step timer: one-cycle tick every PERIOD counting cycles, with
// clear (to 0), enable (count) and freeze (hold the current count).
module step_tick_gen #(
  parameter int PERIOD = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clear,
  input  logic enable,
  input  logic freeze,
  output logic tick
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && !freeze && !clear && (cnt == LAST);

  // Count while enabled and not frozen, wrapping to 0 on the tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !freeze) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/servo_slew_limiter.sv
// Clamps the requested servo pulse width and rate-limits the value
// handed to pwm_driver; reports busy/settled status.
module servo_slew_limiter
  import servo_pkg::*;
#(
  parameter int STEP_PERIOD_CLKS = 50000,
  parameter int STEP_SIZE        = 10,
  parameter int MIN_PW           = MIN_PW_DEF,
  parameter int MAX_PW           = MAX_PW_DEF,
  parameter int RESET_PW         = RESET_PW_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  servo_slew_limiter_if.slave  bus
);

  localparam pw_t MIN_V   = pw_t'(MIN_PW);
  localparam pw_t MAX_V   = pw_t'(MAX_PW);
  localparam pw_t RESET_V = pw_t'(RESET_PW);
  localparam pw_t STEP_V  = pw_t'(STEP_SIZE);
  localparam logic [DATA_W:0] STEP_D = (DATA_W+1)'(STEP_SIZE);

  slew_state_t     state, state_nxt;
  pw_t             clamped, target_q, data_q, data_nxt;
  logic [DATA_W:0] diff;
  logic            up;
  logic            tick;
  logic            final_step;
  logic            update_q;
  logic            tick_clear, tick_enable;

  // Unsigned clamp of the raw request into the legal servo range.
  always_comb begin
    clamped = bus.i_target;
    if (bus.i_target < MIN_V)      clamped = MIN_V;
    else if (bus.i_target > MAX_V) clamped = MAX_V;
  end

  // One-cycle input register for the clamped target.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) target_q <= RESET_V;
    else          target_q <= clamped;
  end

  assign tick_clear  = (state == ST_IDLE) || !bus.i_enable;
  assign tick_enable = (state == ST_RAMP);

  step_tick_gen #(
    .PERIOD (STEP_PERIOD_CLKS)
  ) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clear   (tick_clear),
    .enable  (tick_enable),
    .freeze  (bus.i_hold),
    .tick    (tick)
  );

  // Step arithmetic: distance is taken one bit wider so it never wraps,
  // and a step that would overshoot lands exactly on the target instead.
  always_comb begin
    up         = (target_q > data_q);
    diff       = up ? ({1'b0, target_q} - {1'b0, data_q})
                    : ({1'b0, data_q} - {1'b0, target_q});
    final_step = (diff <= STEP_D);
    data_nxt   = data_q;
    if (!bus.i_enable) begin
      data_nxt = target_q;
    end else if (tick) begin
      if (final_step) data_nxt = target_q;
      else if (up)    data_nxt = data_q + STEP_V;
      else            data_nxt = data_q - STEP_V;
    end
  end

  // State, output value and update strobe registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      data_q   <= RESET_V;
      update_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      data_q   <= data_nxt;
      update_q <= (data_nxt != data_q);
    end
  end

  // Next-state decode; bypass wins over everything, including hold.
  always_comb begin
    state_nxt = state;
    if (!bus.i_enable) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (!bus.i_hold && (data_q != target_q)) state_nxt = ST_RAMP;
        ST_RAMP: begin
          if (bus.i_hold)                state_nxt = ST_HOLD;
          else if (data_q == target_q)   state_nxt = ST_IDLE;
          else if (tick && final_step)   state_nxt = ST_IDLE;
        end
        ST_HOLD: if (!bus.i_hold) state_nxt = ST_RAMP;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Status outputs for the overlay and replay sequencer.
  always_comb begin
    bus.o_busy    = ((state == ST_RAMP) || (state == ST_HOLD)) && (data_q != target_q);
    bus.o_settled = (state == ST_IDLE) && (data_q == target_q);
  end

  assign bus.o_data   = data_q;
  assign bus.o_update = update_q;

endmodule

// File: tb/tb_servo_slew_limiter.sv
`timescale 1ns/1ps
module tb_servo_slew_limiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   upd_cnt;
  int   min_seen;
  int   max_seen;

  servo_slew_limiter_if bus ();

  servo_slew_limiter #(
    .STEP_PERIOD_CLKS (4),
    .STEP_SIZE        (10)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, sampling 1 ns after each edge.
  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_update === 1'b1) upd_cnt++;
      if (int'(bus.o_data) < min_seen) min_seen = int'(bus.o_data);
      if (int'(bus.o_data) > max_seen) max_seen = int'(bus.o_data);
    end
  endtask

  task automatic clr_stats();
    upd_cnt  = 0;
    min_seen = 8191;
    max_seen = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr_stats();
    rst_n        = 1'b0;
    bus.i_target = 13'd1500;
    bus.i_enable = 1'b1;
    bus.i_hold   = 1'b0;
    step_n(3);
    check("rst_data",    bus.o_data, 1500);
    check("rst_settled", bus.o_settled, 1);
    check("rst_busy",    bus.o_busy, 0);
    check("rst_update",  bus.o_update, 0);

    // Idle after reset
    rst_n = 1'b1;
    clr_stats();
    step_n(20);
    check("idle_data",    bus.o_data, 1500);
    check("idle_settled", bus.o_settled, 1);
    check("idle_busy",    bus.o_busy, 0);
    check("idle_updates", upd_cnt, 0);

    // Small ramp 1500 -> 1530
    clr_stats();
    bus.i_target = 13'd1530;
    step_n(5);
    check("r1_pre_data", bus.o_data, 1500);
    check("r1_busy",     bus.o_busy, 1);
    check("r1_pre_upd",  bus.o_update, 0);
    step_n(1);
    check("r1_s1_data", bus.o_data, 1510);
    check("r1_s1_upd",  bus.o_update, 1);
    step_n(3);
    check("r1_mid_data", bus.o_data, 1510);
    step_n(1);
    check("r1_s2_data", bus.o_data, 1520);
    check("r1_s2_upd",  bus.o_update, 1);
    step_n(4);
    check("r1_s3_data",    bus.o_data, 1530);
    check("r1_s3_upd",     bus.o_update, 1);
    check("r1_settled",    bus.o_settled, 1);
    check("r1_busy_done",  bus.o_busy, 0);
    check("r1_upd_count",  upd_cnt, 3);

    // Clamp high: 3000 -> 2500, 97 steps from 1530
    clr_stats();
    bus.i_target = 13'd3000;
    step_n(400);
    check("hi_data",    bus.o_data, 2500);
    check("hi_settled", bus.o_settled, 1);
    check("hi_updates", upd_cnt, 97);
    check("hi_max",     max_seen, 2500);

    // Clamp low: 100 -> 500, 200 steps from 2500
    clr_stats();
    bus.i_target = 13'd100;
    step_n(810);
    check("lo_data",    bus.o_data, 500);
    check("lo_settled", bus.o_settled, 1);
    check("lo_updates", upd_cnt, 200);
    check("lo_min",     min_seen, 500);
    check("lo_max",     max_seen, 2500);

    // Bypass back to 1500
    clr_stats();
    bus.i_enable = 1'b0;
    bus.i_target = 13'd1500;
    step_n(1);
    check("bp1_lat1_data", bus.o_data, 500);
    step_n(1);
    check("bp1_data", bus.o_data, 1500);
    check("bp1_upd",  bus.o_update, 1);
    bus.i_enable = 1'b1;
    step_n(1);
    check("bp1_upd_off", bus.o_update, 0);

    // Hold mid-ramp 1500 -> 1600 at 1530
    clr_stats();
    bus.i_target = 13'd1600;
    step_n(14);
    check("h_pre_data", bus.o_data, 1530);
    step_n(2);
    clr_stats();
    bus.i_hold = 1'b1;
    step_n(10);
    check("h_frozen_data", bus.o_data, 1530);
    check("h_frozen_upd",  upd_cnt, 0);
    check("h_busy",        bus.o_busy, 1);
    bus.i_hold = 1'b0;
    step_n(2);
    check("h_resume_data", bus.o_data, 1530);
    step_n(1);
    check("h_step_data", bus.o_data, 1540);
    check("h_step_upd",  bus.o_update, 1);

    // Return to 1500 through bypass
    bus.i_enable = 1'b0;
    bus.i_target = 13'd1500;
    step_n(3);
    check("bp2_data", bus.o_data, 1500);
    bus.i_enable = 1'b1;
    step_n(2);

    // Target reversal mid-ramp
    clr_stats();
    bus.i_target = 13'd1600;
    step_n(10);
    check("rev_pre_data", bus.o_data, 1520);
    bus.i_target = 13'd1505;
    step_n(4);
    check("rev_s1_data", bus.o_data, 1510);
    step_n(4);
    check("rev_s2_data",  bus.o_data, 1505);
    check("rev_settled",  bus.o_settled, 1);
    check("rev_busy",     bus.o_busy, 0);
    check("rev_updates",  upd_cnt, 4);

    // Bypass jump to 2000
    clr_stats();
    bus.i_enable = 1'b0;
    bus.i_target = 13'd2000;
    step_n(1);
    check("bp3_lat1_data", bus.o_data, 1505);
    check("bp3_lat1_upd",  bus.o_update, 0);
    step_n(1);
    check("bp3_data", bus.o_data, 2000);
    check("bp3_upd",  bus.o_update, 1);
    step_n(3);
    check("bp3_upd_count", upd_cnt, 1);
    check("bp3_settled",   bus.o_settled, 1);

    // Async reset mid-ramp
    bus.i_enable = 1'b1;
    bus.i_target = 13'd1600;
    step_n(7);
    check("ar_pre_data", bus.o_data, 1990);
    rst_n = 1'b0;
    #1;
    check("ar_data",    bus.o_data, 1500);
    check("ar_settled", bus.o_settled, 1);
    check("ar_busy",    bus.o_busy, 0);
    check("ar_update",  bus.o_update, 0);
    step_n(2);
    rst_n = 1'b1;
    step_n(3);
    check("ar_post_data", bus.o_data, 1500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
